// File: rtl/mips_pkg.sv
// Shared types and limits for the data-memory arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    // Upper bound on consecutive DMA grants while the CPU is waiting.
    localparam int DMA_BURST_MAX = 15;

    // Arbiter state records who owned the memory port in the last cycle.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DMA  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU / DMA / data-memory signal bundle around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: CPU sees cpu_stall, DMA sees dma_gnt; memory never stalls.
interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arb_fsm.sv
// Grant decision between CPU and DMA with a bounded DMA burst.
// Latency: grants are combinational from state, count and requests.
// Backpressure: at most one grant per cycle; no grants while rst is high.
module dmem_arb_fsm
    import mips_pkg::*;
#(
    parameter int DMA_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic dma_req,
    output logic gnt_cpu,
    output logic gnt_dma
);

    // Out-of-range burst settings are clamped into 1..DMA_BURST_MAX.
    localparam int BURST_EFF = (DMA_BURST < 1) ? 1 :
                               (DMA_BURST > DMA_BURST_MAX) ? DMA_BURST_MAX : DMA_BURST;
    localparam logic [3:0] BURST = 4'(BURST_EFF);

    arb_state_t state;
    logic [3:0] cnt;

    // Pick one requester; contention rotates CPU -> DMA burst -> CPU.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_dma = 1'b0;
        if (!rst) begin
            if (cpu_req && dma_req) begin
                case (state)
                    ARB_IDLE: gnt_cpu = 1'b1;
                    ARB_CPU:  gnt_dma = 1'b1;
                    ARB_DMA: begin
                        if (cnt < BURST) gnt_dma = 1'b1;
                        else             gnt_cpu = 1'b1;
                    end
                    default:  gnt_cpu = 1'b1;
                endcase
            end else if (cpu_req) begin
                gnt_cpu = 1'b1;
            end else if (dma_req) begin
                gnt_dma = 1'b1;
            end
        end
    end

    // Remember the last grantee and count consecutive DMA grants (saturating).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
            cnt   <= 4'd0;
        end else if (gnt_dma) begin
            state <= ARB_DMA;
            cnt   <= (cnt >= BURST) ? BURST : cnt + 4'd1;
        end else if (gnt_cpu) begin
            state <= ARB_CPU;
            cnt   <= 4'd0;
        end else begin
            state <= ARB_IDLE;
            cnt   <= 4'd0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU and a DMA/loader.
// Latency: grant and memory drive same cycle; DMA read data one cycle after grant.
// Backpressure: CPU stalled via cpu_stall; DMA holds its request until dma_gnt.
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int DMA_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    logic gnt_cpu;
    logic gnt_dma;

    dmem_arb_fsm #(
        .DMA_BURST (DMA_BURST)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .cpu_req (bus.cpu_req),
        .dma_req (bus.dma_req),
        .gnt_cpu (gnt_cpu),
        .gnt_dma (gnt_dma)
    );

    // Memory port follows the grantee; with no DMA grant the CPU fields pass through.
    assign bus.mem_we    = gnt_cpu ? bus.cpu_we : (gnt_dma ? bus.dma_we : 1'b0);
    assign bus.mem_addr  = gnt_dma ? bus.dma_addr  : bus.cpu_addr;
    assign bus.mem_wdata = gnt_dma ? bus.dma_wdata : bus.cpu_wdata;

    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_stall = bus.cpu_req & ~gnt_cpu;
    assign bus.dma_gnt   = gnt_dma;

    // Capture DMA read data at the end of its grant cycle; hold it otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dma_rvalid <= 1'b0;
            bus.dma_rdata  <= 32'd0;
        end else begin
            bus.dma_rvalid <= gnt_dma & ~bus.dma_we;
            if (gnt_dma && !bus.dma_we) begin
                bus.dma_rdata <= bus.mem_rdata;
            end
        end
    end

endmodule
